uart_tx_strobe: RTL and testbench

- Serial transmitter that consumes the divided bit-rate clock from the clock divider and shifts out one UART frame per accepted byte.
- `tick_in` is the divider output, sampled as a level in the `clk_in` domain; each rising edge marks one bit-time boundary.
- Sits between the byte source (debug/console logic) and the board TX pin; line idles high.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_strobe_tick_edge.sv | 19 +
 rtl/uart_tx_strobe.sv | 137 +++++++++++++
 tb/tb_uart_tx_strobe.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit path.
// Parity support is built when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_strobe_tick_edge.sv
// Rising-edge detector for the divided bit-rate clock level.
// Shared with the receive path for clock recovery.
module tick_edge (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic tick_in,
    output logic strobe
);

    logic tick_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) tick_q <= 1'b0;
        else           tick_q <= tick_in;
    end

    assign strobe = tick_in & ~tick_q;

endmodule

// File: rtl/uart_tx_strobe.sv
// UART frame transmitter stepped by bit-time strobes from tick_in.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data.
module uart_tx_strobe
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 tick_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx_out,
    output logic                 busy_out
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS);

    tx_state_e            state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 strobe;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    tick_edge u_tick_edge (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tick_in  (tick_in),
        .strobe   (strobe)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            tx_q    <= LINE_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (valid_in) begin
                    sh_d    = data_in;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (strobe) begin
                    state_d = ST_START;
                    tx_d    = LINE_START;
                end
            end
            ST_START: begin
                if (strobe) begin
                    state_d = ST_DATA;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                    cnt_d   = 4'd0;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = LINE_IDLE;
                        cnt_d   = 4'd1;
`endif
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (strobe) begin
                    state_d = ST_STOP;
                    tx_d    = LINE_IDLE;
                    cnt_d   = 4'd1;
                end
            end
`endif
            // the entry strobe already counted as the first stop bit
            ST_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = ST_IDLE;
                end else if (strobe) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
    end

    assign tx_out    = tx_q;
    assign ready_out = (state_q == ST_IDLE);
    assign busy_out  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_strobe.sv
// Self-checking bench for uart_tx_strobe with one and two stop bits.
// Checks every cycle against a frame-queue model plus directed frames.
module tb_uart_tx_strobe;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       rdy0, tx0, bsy0;
    logic       rdy1, tx1, bsy1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int tcnt = 0;
    int hi = 4;
    int lo = 4;

    logic        m_tq;
    logic        m_line[2];
    logic        m_rdy[2];
    logic [15:0] m_fr[2];
    int          m_left[2];
    int          sb[2];

    int   lg_t[$];
    logic lg0[$];
    logic lg1[$];
    logic h1[$];

    typedef struct {
        logic [7:0] d;
        logic       par;
    } vec_t;
    vec_t tbl[8];

    uart_tx_strobe #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .tick_in   (tick),
        .data_in   (data),
        .valid_in  (valid),
        .ready_out (rdy0),
        .tx_out    (tx0),
        .busy_out  (bsy0)
    );

    uart_tx_strobe #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .tick_in   (tick),
        .data_in   (data),
        .valid_in  (valid),
        .ready_out (rdy1),
        .tx_out    (tx1),
        .busy_out  (bsy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
        end
    endtask

    // line bits in send order, LSB = first bit on the wire
    function automatic logic [15:0] frame(input logic [7:0] d);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (P == 1) f[9] = ^d;
        return f;
    endfunction

    function automatic logic [15:0] exp_frame(input logic [7:0] d,
                                              input logic par);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (P == 1) f[9] = par;
        return f;
    endfunction

    task automatic step();
        logic stb;
        @(posedge clk);
        #1;
        stb = tick & ~m_tq;
        m_tq = rst_n ? tick : 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_line[i] = 1'b1;
                m_rdy[i]  = 1'b1;
                m_left[i] = 0;
            end else if (m_rdy[i]) begin
                if (valid) begin
                    m_fr[i]   = frame(data);
                    m_left[i] = 1 + 8 + P + sb[i];
                    m_rdy[i]  = 1'b0;
                end
            end else if (m_left[i] == 0) begin
                m_rdy[i] = 1'b1;
            end else if (stb) begin
                m_line[i] = m_fr[i][0];
                m_fr[i]   = m_fr[i] >> 1;
                m_left[i]--;
            end
        end
        chk("tx0", tx0, m_line[0]);
        chk("ready0", rdy0, m_rdy[0]);
        chk("busy0", bsy0, ~m_rdy[0]);
        chk("tx1", tx1, m_line[1]);
        chk("ready1", rdy1, m_rdy[1]);
        chk("busy1", bsy1, ~m_rdy[1]);
        if (stb) begin
            lg_t.push_back(cyc);
            lg0.push_back(tx0);
            lg1.push_back(tx1);
        end
        h1.push_back(tx1);
        cyc++;
        tcnt++;
        if (tick && tcnt >= hi) begin
            tick = 1'b0;
            tcnt = 0;
        end else if (!tick && tcnt >= lo) begin
            tick = 1'b1;
            tcnt = 0;
        end
    endtask

    task automatic clear_log();
        lg_t.delete();
        lg0.delete();
        lg1.delete();
    endtask

    task automatic send(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(rdy0 === 1'b1 && rdy1 === 1'b1) && n < 2000) begin
            step();
            n++;
        end
        n_vec++;
        if (n >= 2000) begin
            n_err++;
            $display("FAIL %s timeout got=busy want=idle", nm);
        end
    endtask

    function automatic int first_zero(input int w, input int from);
        for (int i = from; i < lg_t.size(); i++) begin
            if ((w == 1 ? lg1[i] : lg0[i]) === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic get_frame(input int w, input int from, input int nb,
                             output logic [15:0] f, output int s);
        f = 'x;
        s = first_zero(w, from);
        if (s >= 0) begin
            for (int k = 0; k < nb; k++) begin
                if (s + k < lg_t.size())
                    f[k] = (w == 1) ? lg1[s + k] : lg0[s + k];
            end
        end
    endtask

    task automatic chk_frame(input string nm, input logic [15:0] got,
                             input logic [15:0] exp, input int nb);
        logic [15:0] mask;
        mask = (16'h1 << nb) - 16'h1;
        chkw(nm, {16'h0, got & mask}, {16'h0, exp & mask});
    endtask

    initial begin
        logic [15:0] f, f2;
        int s, s2, n, gap, cnt, t0;

        sb[0] = 1;
        sb[1] = 2;
        m_tq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_line[i] = 1'b1;
            m_rdy[i]  = 1'b1;
            m_fr[i]   = '1;
            m_left[i] = 0;
        end
        tbl[0] = '{8'h55, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'hA3, 1'b0};
        tbl[3] = '{8'h0F, 1'b0};
        tbl[4] = '{8'hFF, 1'b0};
        tbl[5] = '{8'h00, 1'b0};
        tbl[6] = '{8'h80, 1'b1};
        tbl[7] = '{8'hC1, 1'b1};

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // table frames on both stop-bit variants
        for (int v = 0; v < 8; v++) begin
            clear_log();
            send(tbl[v].d);
            wait_idle("tbl_idle");
            repeat (3) step();
            get_frame(0, 0, 10 + P, f, s);
            chk_frame("tbl_frame_s1", f, exp_frame(tbl[v].d, tbl[v].par),
                      10 + P);
            get_frame(1, 0, 11 + P, f, s);
            chk_frame("tbl_frame_s2", f, exp_frame(tbl[v].d, tbl[v].par),
                      11 + P);
        end

        // back-to-back with valid held high
        clear_log();
        data  = 8'hA3;
        valid = 1'b1;
        step();
        data = 8'h0F;
        n = 0;
        while (rdy0 !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("b2b_ready", rdy0, 1'b1);
        step();
        valid = 1'b0;
        wait_idle("b2b_idle");
        repeat (3) step();
        get_frame(0, 0, 10 + P, f, s);
        chk_frame("b2b_first", f, exp_frame(8'hA3, 1'b0), 10 + P);
        s2 = (s >= 0) ? first_zero(0, s + 10 + P) : -1;
        get_frame(0, (s2 >= 0) ? s2 : 0, 10 + P, f2, n);
        gap = (s >= 0 && s2 >= 0) ? lg_t[s2] - lg_t[s + 9 + P] : -1;
        chkw("b2b_gap", gap, 8);
        chk_frame("b2b_second", f2, exp_frame(8'h0F, 1'b0), 10 + P);

        // reset after three data bits of 0xFF
        clear_log();
        send(8'hFF);
        n = 0;
        while (n < 400) begin
            step();
            n++;
            s = first_zero(0, 0);
            if (s >= 0 && lg_t.size() >= s + 4) break;
        end
        chk("rst_reach", (n < 400), 1'b1);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("rst_tx", tx0, 1'b1);
        chk("rst_busy", bsy0, 1'b0);
        chk("rst_ready", rdy0, 1'b1);
        rst_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            step();
            if (tx0 === 1'b1 && tx1 === 1'b1) cnt++;
        end
        chkw("rst_idle100", cnt, 100);

        // data and valid wiggle mid-frame
        clear_log();
        send(8'h3C);
        repeat (20) begin
            data = 8'($urandom);
            step();
        end
        valid = 1'b1;
        data  = 8'hE7;
        repeat (2) step();
        valid = 1'b0;
        data  = 8'($urandom);
        wait_idle("mid_idle");
        get_frame(0, 0, 10 + P, f, s);
        chk_frame("mid_frame", f, exp_frame(8'h3C, 1'b0), 10 + P);
        cnt = 0;
        repeat (40) begin
            step();
            if (bsy0 !== 1'b0 || bsy1 !== 1'b0) cnt++;
        end
        chkw("mid_no_second", cnt, 0);

        // two stop bits: line high for two bit-times
        clear_log();
        send(8'h00);
        wait_idle("s2_idle");
        repeat (10) step();
        get_frame(1, 0, 11 + P, f, s);
        chk_frame("s2_frame", f, exp_frame(8'h00, 1'b0), 11 + P);
        cnt = 0;
        if (s >= 0 && s + 9 + P < lg_t.size()) begin
            t0 = lg_t[s + 9 + P];
            for (int k = 0; k < 16; k++) begin
                if (t0 + k < h1.size() && h1[t0 + k] === 1'b1) cnt++;
            end
        end
        chkw("s2_stop_high", cnt, 16);

        // randomized traffic, tick shape and resets
        for (int blk = 0; blk < 15; blk++) begin
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 6);
            repeat (200) begin
                valid = ($urandom % 4 == 0);
                data  = 8'($urandom);
                rst_n = ($urandom % 400 != 0);
                step();
            end
        end
        rst_n = 1'b1;
        valid = 1'b0;
        hi = 4;
        lo = 4;
        wait_idle("rand_idle");
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
